// File: rtl/framebuffer_pkg.sv
// Shared framebuffer constants and the pixel reader state encoding.
package framebuffer_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH     = 32;
    localparam int unsigned DEFAULT_ADDRESS_LENGTH = 14;
    localparam int unsigned DEFAULT_FRAME_WORDS    = 9600;
    localparam int unsigned BIT_INDEX_WIDTH        = $clog2(DEFAULT_DATA_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH_FIRST,
        ST_WAIT_FIRST,
        ST_STREAM
    } reader_state_e;

endpackage

// File: rtl/pixel_shift_buffer.sv
// Double-buffered word serialiser: MSB-first shift register fed from a prefetch slot.
module pixel_shift_buffer
    import framebuffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  prefetch,
    input  logic                  accept,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  pixel,
    output logic                  prefetch_full,
    output logic                  last_bit_c
);

    localparam int unsigned IDX_WIDTH = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] slot;
    logic [IDX_WIDTH-1:0]  bit_index;

    assign last_bit_c = (bit_index == IDX_WIDTH'(DATA_WIDTH - 1));
    assign pixel      = shift_reg[DATA_WIDTH-1];

    // The slot is zeroed when consumed so an exhausted frame leaves pixel low.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg     <= '0;
            slot          <= '0;
            prefetch_full <= 1'b0;
            bit_index     <= '0;
        end else begin
            if (load) begin
                shift_reg <= data;
                bit_index <= '0;
            end else if (accept) begin
                if (last_bit_c) begin
                    shift_reg     <= slot;
                    slot          <= '0;
                    prefetch_full <= 1'b0;
                    bit_index     <= '0;
                end else begin
                    shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                    bit_index <= bit_index + IDX_WIDTH'(1);
                end
            end
            if (prefetch) begin
                slot          <= data;
                prefetch_full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/framebuffer_pixel_reader.sv
// Linear framebuffer scanner: fetches words from block RAM and streams them as 1-bit pixels.
module framebuffer_pixel_reader
    import framebuffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDRESS_LENGTH = DEFAULT_ADDRESS_LENGTH,
    parameter int unsigned FRAME_WORDS    = DEFAULT_FRAME_WORDS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_frame,
    output logic                      rd_en,
    output logic [ADDRESS_LENGTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      pixel_out,
    output logic                      pixel_valid,
    input  logic                      pixel_ready,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int unsigned CNT_WIDTH = ADDRESS_LENGTH + 1;

    reader_state_e        state;
    reader_state_e        state_next;
    logic [CNT_WIDTH-1:0] words_issued;
    logic                 rd_pending;
    logic                 prefetch_full;
    logic                 last_bit;
    logic                 accept;
    logic                 word_end;
    logic                 frame_end;
    logic                 more_words;
    logic                 start_accept;
    logic                 load;
    logic                 prefetch;
    logic                 issue;

    assign accept     = pixel_valid && pixel_ready;
    assign word_end   = accept && last_bit;
    assign frame_end  = (state == ST_STREAM) && word_end && !prefetch_full;
    assign more_words = (words_issued < CNT_WIDTH'(FRAME_WORDS));

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:        if (start_frame && !frame_done) state_next = ST_FETCH_FIRST;
            ST_FETCH_FIRST: state_next = ST_WAIT_FIRST;
            ST_WAIT_FIRST:  state_next = ST_STREAM;
            ST_STREAM:      if (frame_end) state_next = ST_IDLE;
            default:        state_next = ST_IDLE;
        endcase
    end

    // Next read is issued in the first cycle a fresh word sits in the shift register.
    always_comb begin
        start_accept = 1'b0;
        load         = 1'b0;
        prefetch     = 1'b0;
        issue        = 1'b0;
        case (state)
            ST_IDLE:       start_accept = start_frame && !frame_done;
            ST_WAIT_FIRST: begin
                load  = 1'b1;
                issue = more_words;
            end
            ST_STREAM: begin
                prefetch = rd_pending;
                issue    = word_end && prefetch_full && more_words;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            rd_pending   <= 1'b0;
            words_issued <= '0;
            pixel_valid  <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            rd_en      <= start_accept || issue;
            rd_pending <= rd_en;
            frame_done <= frame_end;
            if (start_accept) begin
                rd_addr      <= '0;
                words_issued <= CNT_WIDTH'(1);
            end else if (issue) begin
                rd_addr      <= rd_addr + ADDRESS_LENGTH'(1);
                words_issued <= words_issued + CNT_WIDTH'(1);
            end
            if (start_accept)   busy <= 1'b1;
            else if (frame_end) busy <= 1'b0;
            if (load)           pixel_valid <= 1'b1;
            else if (frame_end) pixel_valid <= 1'b0;
        end
    end

    pixel_shift_buffer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_shift_buffer (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .prefetch     (prefetch),
        .accept       (accept),
        .data         (rd_data),
        .pixel        (pixel_out),
        .prefetch_full(prefetch_full),
        .last_bit_c   (last_bit)
    );

endmodule

// File: doc/framebuffer_pixel_reader.md
Name: framebuffer_pixel_reader

Overview:
- Read side of the 1-bit-per-pixel framebuffer. The pixel writer sets bits in this framebuffer with read-modify-write.
- Scans the framebuffer linearly from word 0 to FRAME_WORDS-1 and fetches words from the synchronous block RAM read port.
- Serialises each word MSB-first into a valid/ready pixel stream for the display timing block.
- Double-buffers words (shift register plus prefetch slot), so a continuously ready sink sees one pixel per cycle with no bubbles after the first.

Parameters:
- DATA_WIDTH, 32, bits per framebuffer word; also pixels per word.
- ADDRESS_LENGTH, 14, width of the RAM word address.
- FRAME_WORDS, 9600, number of words scanned per frame (640x480/32). Legal range is 1..2**ADDRESS_LENGTH.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start_frame  in  1  single-cycle pulse that begins a frame scan; ignored while busy.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  ADDRESS_LENGTH  RAM word address.
- rd_data  in  DATA_WIDTH  RAM read data, valid in the cycle after rd_en.
- pixel_out  out  1  current pixel value.
- pixel_valid  out  1  pixel_out holds a valid pixel.
- pixel_ready  in  1  sink accepts the pixel when pixel_valid && pixel_ready.
- busy  out  1  high from the start_frame acceptance cycle until frame_done.
- frame_done  out  1  one-cycle pulse after the last pixel of the frame is accepted.

Behaviour:
- Reset values: rd_en=0, rd_addr=0, pixel_out=0, pixel_valid=0, busy=0, frame_done=0. Word counter, bit index and both buffers are cleared.
- Bit mapping: pixel at offset b of a word is bit DATA_WIDTH-1-b. Offset 0 is the MSB and is emitted first, matching the writer's offset convention.
- RAM timing: rd_en and rd_addr are registered. Data requested in cycle N is sampled from rd_data at the end of cycle N+1.
- State machine states: Idle, FetchFirst, WaitFirst, Stream.
- Idle: on start_frame go to FetchFirst; busy=1 from the next cycle.
- FetchFirst: rd_en=1, rd_addr=0, then go to WaitFirst.
- WaitFirst: capture rd_data into the shift register, then go to Stream. pixel_valid=1 from the following cycle.
- Latency: start_frame sampled at cycle 0 gives rd_en at cycle 1 and the first pixel_valid at cycle 3.
- Prefetch: in the first Stream cycle of each word, if another word remains, assert rd_en for the next address. Capture it into the prefetch slot and set prefetch_full.
- Prefetch timing guarantee: for DATA_WIDTH>=4 the prefetched word always arrives before its shift-register word drains.
- Handshake: pixel_out and pixel_valid stay stable while pixel_valid && !pixel_ready. The bit index advances only on acceptance.
- Word boundary: when the pixel at offset DATA_WIDTH-1 is accepted, the prefetch slot loads into the shift register in the same edge and bit index resets to 0. The next cycle presents the new word's MSB with no bubble.
- rd_en is a one-cycle pulse per word. Reads are exactly addresses 0..FRAME_WORDS-1, in order, once each per frame. No read is issued at an address >= FRAME_WORDS.
- End of frame: when the last pixel of word FRAME_WORDS-1 is accepted, pixel_valid=0 and frame_done=1 for one cycle on the next edge. busy drops at the same edge and the block returns to Idle.
- FRAME_WORDS=1: no prefetch is issued, and frame_done follows the DATA_WIDTH-th acceptance.
- start_frame while busy (including the frame_done cycle): ignored. A start_frame in the cycle after frame_done is accepted.
- reset mid-frame: all state returns to reset values on the next edge. Buffers are discarded, pixel_valid=0 and frame_done is not pulsed.
- The RAM address counter is ADDRESS_LENGTH bits wide. The bit index is $clog2(DATA_WIDTH) bits wide and compares against DATA_WIDTH-1 explicitly.

Decomposition:
- Package framebuffer_pkg holds:
  - the reader state encoding (Idle, FetchFirst, WaitFirst, Stream);
  - localparam BIT_INDEX_WIDTH = $clog2(DATA_WIDTH);
  - defaults for DATA_WIDTH, ADDRESS_LENGTH and FRAME_WORDS, shared with the writer.
- One sub-module, pixel_shift_buffer: shift register, prefetch slot, prefetch_full flag and bit index, with load, prefetch and accept inputs.
- The top level keeps the FSM, address counter and RAM interface.

Test Plan:
- RAM model loaded with word0=32'h8000_0001 and word1=32'hFFFF_0000; FRAME_WORDS=2; pixel_ready held at 1; pulse start_frame. Expect rd_en at cycles 1 and 3 with addresses 0 and 1, first pixel_valid at cycle 3, and pixels 1,0×30,1 then 1×16,0×16. Expect 64 contiguous valid cycles and frame_done one cycle after the 64th pixel.
- Same frame with pixel_ready toggling 1,0,0,1 pseudo-randomly. Expect an identical 64-pixel sequence, pixel_out stable while stalled, and exactly one read per address.
- FRAME_WORDS=1, word0=32'h0000_0001. Expect 31 zeros then 1, a single rd_en at address 0, and frame_done after the 32nd acceptance.
- start_frame pulsed again mid-frame and in the frame_done cycle. Expect both to be ignored. A start_frame one cycle after frame_done must restart with rd_addr=0.
- Assert reset at pixel 40 of a 2-word frame. Expect all outputs at reset values next cycle and no frame_done. A following start_frame must rescan from address 0.
- FRAME_WORDS=9600 with a full-frame random image and a sink ready with 75% probability. Expect a scoreboard bit-exact match of all 307200 pixels and the rd_addr sequence 0..9599.
